// File: rtl/wb_regfile.sv
// LEGv8 writeback stage and 32x64 architectural register file.
// Selects load data or ALU result, commits it on the rising edge, serves two
// combinational read ports with optional same-cycle bypass, hardwires XZR to
// zero and keeps a wrapping count of committed writes.
module wb_regfile #(
  parameter int DATA_W   = 64,
  parameter int NUM_REGS = 32,
  parameter int ZERO_REG = 31,
  parameter int BYPASS   = 1,
  parameter int CNT_W    = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] Read_data,
  input  logic [DATA_W-1:0] Alu_result,
  input  logic [4:0]        Write_reg,
  input  logic              RegWrite,
  input  logic              MemtoReg,
  input  logic [4:0]        read_reg1,
  input  logic [4:0]        read_reg2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_commit,
  output logic [CNT_W-1:0]  wb_count
);

  localparam logic [4:0] ZR_IDX = 5'(ZERO_REG);
  localparam bit         BYP_EN = (BYPASS != 0);

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic              r_commit;
  logic [CNT_W-1:0]  r_count;

  logic              w_we;
  logic [DATA_W-1:0] w_wb_data;
  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd2;

  // Writeback mux and write qualification; writes to XZR are dropped entirely.
  always_comb begin
    w_wb_data = Alu_result;
    if (MemtoReg) begin
      w_wb_data = Read_data;
    end else begin
      w_wb_data = Alu_result;
    end
    w_we = RegWrite && (Write_reg != ZR_IDX);
  end

  // Read port 1: XZR reads zero, then same-cycle bypass, then stored value.
  always_comb begin
    w_rd1 = '0;
    if (read_reg1 == ZR_IDX) begin
      w_rd1 = '0;
    end else if (BYP_EN && w_we && (Write_reg == read_reg1)) begin
      w_rd1 = w_wb_data;
    end else begin
      w_rd1 = r_regs[read_reg1];
    end
  end

  // Read port 2: same priority as port 1, independent index.
  always_comb begin
    w_rd2 = '0;
    if (read_reg2 == ZR_IDX) begin
      w_rd2 = '0;
    end else if (BYP_EN && w_we && (Write_reg == read_reg2)) begin
      w_rd2 = w_wb_data;
    end else begin
      w_rd2 = r_regs[read_reg2];
    end
  end

  // Register array commit; reset wins over any write on the same edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_we) begin
      r_regs[Write_reg] <= w_wb_data;
    end
  end

  // Commit flag and retired-write counter; the counter wraps without saturating.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_commit <= 1'b0;
      r_count  <= '0;
    end else begin
      r_commit <= w_we;
      if (w_we) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign wb_data    = w_wb_data;
  assign read_data1 = w_rd1;
  assign read_data2 = w_rd2;
  assign wb_commit  = r_commit;
  assign wb_count   = r_count;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed scoreboard bench for wb_regfile: a default instance (bypass on,
// 32-bit counter) and a second instance (bypass off, 4-bit counter) share the
// same stimulus so bypass-off reads and counter wrap are covered together.
module tb_wb_regfile;

  logic        clock;
  logic        reset;
  logic [63:0] Read_data;
  logic [63:0] Alu_result;
  logic [4:0]  Write_reg;
  logic        RegWrite;
  logic        MemtoReg;
  logic [4:0]  read_reg1;
  logic [4:0]  read_reg2;

  logic [63:0] a_rd1, a_rd2, a_wb;
  logic        a_commit;
  logic [31:0] a_count;
  logic [63:0] b_rd1, b_rd2, b_wb;
  logic        b_commit;
  logic [3:0]  b_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    int          sel;
    logic [63:0] exp;
  } exp_t;

  exp_t sb[$];

  localparam int S_ARD1 = 0, S_ARD2 = 1, S_AWB = 2, S_ACOM = 3, S_ACNT = 4;
  localparam int S_BRD1 = 5, S_BRD2 = 6, S_BCOM = 7, S_BCNT = 8;

  wb_regfile u_dut_a (
    .clock(clock), .reset(reset), .Read_data(Read_data), .Alu_result(Alu_result),
    .Write_reg(Write_reg), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
    .read_reg1(read_reg1), .read_reg2(read_reg2),
    .read_data1(a_rd1), .read_data2(a_rd2), .wb_data(a_wb),
    .wb_commit(a_commit), .wb_count(a_count)
  );

  wb_regfile #(.BYPASS(0), .CNT_W(4)) u_dut_b (
    .clock(clock), .reset(reset), .Read_data(Read_data), .Alu_result(Alu_result),
    .Write_reg(Write_reg), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
    .read_reg1(read_reg1), .read_reg2(read_reg2),
    .read_data1(b_rd1), .read_data2(b_rd2), .wb_data(b_wb),
    .wb_commit(b_commit), .wb_count(b_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic push(input string tag, input int sel, input logic [63:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [63:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sel)
        S_ARD1:  obs = a_rd1;
        S_ARD2:  obs = a_rd2;
        S_AWB:   obs = a_wb;
        S_ACOM:  obs = {63'd0, a_commit};
        S_ACNT:  obs = {32'd0, a_count};
        S_BRD1:  obs = b_rd1;
        S_BRD2:  obs = b_rd2;
        S_BCOM:  obs = {63'd0, b_commit};
        S_BCNT:  obs = {60'd0, b_count};
        default: obs = 64'hxxxx_xxxx_xxxx_xxxx;
      endcase
      checks++;
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; Read_data = 64'd0; Alu_result = 64'd0; Write_reg = 5'd0;
    RegWrite = 1'b0; MemtoReg = 1'b0; read_reg1 = 5'd1; read_reg2 = 5'd5;
    tick(); tick();
    reset = 1'b0;
    #1;
    // Reset state
    push("rst_a_rd1", S_ARD1, 64'd0); push("rst_a_rd2", S_ARD2, 64'd0);
    push("rst_a_com", S_ACOM, 64'd0); push("rst_a_cnt", S_ACNT, 64'd0);
    push("rst_b_rd1", S_BRD1, 64'd0); push("rst_b_cnt", S_BCNT, 64'd0);
    drain();

    // Write X1 = 0x1234; bypass visible on A only before the edge
    RegWrite = 1'b1; MemtoReg = 1'b0; Alu_result = 64'h1234; Write_reg = 5'd1;
    #1;
    push("x1_byp_a", S_ARD1, 64'h1234); push("x1_nobyp_b", S_BRD1, 64'd0);
    drain();
    tick();
    RegWrite = 1'b0;
    #1;
    push("x1_a", S_ARD1, 64'h1234); push("x1_b", S_BRD1, 64'h1234);
    push("x1_com", S_ACOM, 64'd1);  push("x1_cnt", S_ACNT, 64'd1);
    drain();

    // Asynchronous reset between edges
    #1;
    reset = 1'b1;
    #1;
    push("arst_rd1", S_ARD1, 64'd0); push("arst_cnt", S_ACNT, 64'd0);
    push("arst_com", S_ACOM, 64'd0); push("arst_b_rd1", S_BRD1, 64'd0);
    push("arst_b_cnt", S_BCNT, 64'd0);
    drain();
    // A write presented while reset is held must be discarded
    RegWrite = 1'b1; Write_reg = 5'd2; Alu_result = 64'h99; read_reg1 = 5'd2;
    tick();
    reset = 1'b0; RegWrite = 1'b0;
    #1;
    push("rstwr_rd1", S_ARD1, 64'd0); push("rstwr_cnt", S_ACNT, 64'd0);
    push("rstwr_com", S_ACOM, 64'd0);
    drain();

    // ALU writeback to X5
    RegWrite = 1'b1; MemtoReg = 1'b0; Alu_result = 64'hDEAD_BEEF_0000_0001; Write_reg = 5'd5;
    tick();
    RegWrite = 1'b0; read_reg1 = 5'd5;
    #1;
    push("alu_rd1", S_ARD1, 64'hDEAD_BEEF_0000_0001); push("alu_com", S_ACOM, 64'd1);
    push("alu_cnt", S_ACNT, 64'd1); push("alu_b_cnt", S_BCNT, 64'd1);
    drain();

    // Load writeback to X9, mux picks Read_data
    RegWrite = 1'b1; MemtoReg = 1'b1; Read_data = 64'hAAAA; Alu_result = 64'h5555; Write_reg = 5'd9;
    #1;
    push("ld_wbdata", S_AWB, 64'hAAAA);
    drain();
    MemtoReg = 1'b0;
    #1;
    push("alu_wbdata", S_AWB, 64'h5555);
    drain();
    MemtoReg = 1'b1;
    tick();
    RegWrite = 1'b0; read_reg2 = 5'd9;
    #1;
    push("ld_rd2", S_ARD2, 64'hAAAA); push("ld_cnt", S_ACNT, 64'd2);
    drain();

    // Write attempt to XZR
    RegWrite = 1'b1; MemtoReg = 1'b0; Alu_result = 64'hFFFF; Write_reg = 5'd31; read_reg2 = 5'd31;
    #1;
    push("xzr_byp_rd2", S_ARD2, 64'd0);
    drain();
    tick();
    RegWrite = 1'b0;
    #1;
    push("xzr_rd2", S_ARD2, 64'd0); push("xzr_com", S_ACOM, 64'd0);
    push("xzr_cnt", S_ACNT, 64'd2); push("xzr_b_rd2", S_BRD2, 64'd0);
    drain();

    // Bypass: seed X7 with 0x11, then rewrite with 0x77 and read both ports
    RegWrite = 1'b1; Alu_result = 64'h11; Write_reg = 5'd7;
    tick();
    Alu_result = 64'h77; read_reg1 = 5'd7; read_reg2 = 5'd7;
    #1;
    push("byp_a_rd1", S_ARD1, 64'h77); push("byp_a_rd2", S_ARD2, 64'h77);
    push("byp_b_rd1", S_BRD1, 64'h11); push("byp_b_rd2", S_BRD2, 64'h11);
    drain();
    tick();
    RegWrite = 1'b0;
    #1;
    push("byp_post_a", S_ARD1, 64'h77); push("byp_post_b", S_BRD2, 64'h77);
    push("byp_cnt", S_ACNT, 64'd4); push("byp_b_cnt", S_BCNT, 64'd4);
    drain();

    // Counter wrap on the 4-bit instance: 12 more writes reach 16 -> 0
    RegWrite = 1'b1;
    for (int i = 0; i < 12; i++) begin
      Write_reg = 5'(10 + i);
      Alu_result = 64'h100 + 64'(i);
      tick();
    end
    RegWrite = 1'b0; read_reg1 = 5'd21;
    #1;
    push("wrap_b_cnt", S_BCNT, 64'd0); push("wrap_a_cnt", S_ACNT, 64'd16);
    push("wrap_b_com", S_BCOM, 64'd1); push("wrap_rd1", S_ARD1, 64'h10B);
    drain();
    RegWrite = 1'b1; Write_reg = 5'd3; Alu_result = 64'h3;
    tick();
    RegWrite = 1'b0;
    #1;
    push("wrap17_b_cnt", S_BCNT, 64'd1); push("wrap17_a_cnt", S_ACNT, 64'd17);
    drain();
    tick();
    push("idle_b_com", S_BCOM, 64'd0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
